// File: rtl/tx_top.sv
// rtl/tx_top.sv - UART transmitter: start/busy/done byte handshake, 8 data bits LSB first, optional parity, 1 or 2 stop bits
`timescale 1ns/1ps
module tx_top #(
  parameter int BPS_DIV    = 5208,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       TX_En_Sig,
  input  logic       TX_Start_Sig,
  input  logic [7:0] TX_Data,
  output logic       TX_Pin_Out,
  output logic       TX_Busy_Sig,
  output logic       TX_Done_Sig
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t      state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        par_q, par_d;
  logic        pin_q, pin_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        bit_end;

  assign bit_end = (baud_q == 16'(BPS_DIV - 1));

  always_comb begin
    state_d   = state_q;
    baud_d    = bit_end ? 16'd0 : 16'(baud_q + 16'd1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    par_d     = par_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d = 16'd0;
        if (TX_En_Sig && TX_Start_Sig) begin
          shift_d   = TX_Data;
          par_d     = (^TX_Data) ^ (PARITY_ODD != 0);
          bit_idx_d = 3'd0;
          state_d   = START;
        end
      end
      START: if (bit_end) state_d = DATA;
      DATA: begin
        if (bit_end) begin
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = 3'(bit_idx_q + 3'd1);
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = 3'd0;
            state_d   = (PARITY_EN != 0) ? PARITY : STOP;
          end
        end
      end
      PARITY: if (bit_end) state_d = STOP;
      STOP: begin
        if (bit_end) begin
          if (bit_idx_q == 3'(STOP_BITS - 1)) begin
            bit_idx_d = 3'd0;
            state_d   = IDLE;
            done_d    = 1'b1;
          end else begin
            bit_idx_d = 3'(bit_idx_q + 3'd1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The line is driven from the next state so each bit appears the cycle after its transition edge.
  always_comb begin
    pin_d  = 1'b1;
    busy_d = (state_d != IDLE);
    case (state_d)
      START:   pin_d = 1'b0;
      DATA:    pin_d = shift_d[0];
      PARITY:  pin_d = par_d;
      default: pin_d = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q   <= IDLE;
      baud_q    <= 16'd0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
      par_q     <= 1'b0;
      pin_q     <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      pin_q     <= pin_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign TX_Pin_Out  = pin_q;
  assign TX_Busy_Sig = busy_q;
  assign TX_Done_Sig = done_q;

endmodule

// File: tb/tb_tx_top.sv
// tb/tb_tx_top.sv - directed self-checking bench for tx_top (8-N-1 and 8-E-2 instances, BPS_DIV=16)
`timescale 1ns/1ps
module tb_tx_top;
  localparam int D = 16;

  logic       CLK = 1'b0;
  logic       RSTn = 1'b0;
  logic       en = 1'b0;
  logic       start0 = 1'b0, start1 = 1'b0;
  logic [7:0] data0 = 8'h00, data1 = 8'h00;
  logic       pin0, busy0, done0, pin1, busy1, done1;
  int         tests = 0;
  int         fails = 0;

  always #5 CLK = ~CLK;

  tx_top #(.BPS_DIV(D)) dut0 (
    .CLK(CLK), .RSTn(RSTn), .TX_En_Sig(en), .TX_Start_Sig(start0), .TX_Data(data0),
    .TX_Pin_Out(pin0), .TX_Busy_Sig(busy0), .TX_Done_Sig(done0)
  );

  tx_top #(.BPS_DIV(D), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut1 (
    .CLK(CLK), .RSTn(RSTn), .TX_En_Sig(en), .TX_Start_Sig(start1), .TX_Data(data1),
    .TX_Pin_Out(pin1), .TX_Busy_Sig(busy1), .TX_Done_Sig(done1)
  );

  // Records one frame: bits[k] is the line level of bit k (k=0 start bit), every cycle of a bit must match.
  task automatic capture(input int which, input bit issue, input logic [7:0] b, input int nbits,
                         input bit chain, input logic [7:0] nb, output logic [11:0] bits,
                         output int unstable, output int done_off, output int done_bad);
    logic p, bs, dn;
    int k;
    bits = '0; unstable = 0; done_off = -1; done_bad = 0;
    if (issue) begin
      @(negedge CLK);
      if (which != 0) begin data1 = b; start1 = 1'b1; end
      else begin data0 = b; start0 = 1'b1; end
    end
    @(posedge CLK);
    for (int off = 1; off <= nbits * D; off++) begin
      @(negedge CLK);
      if (off == 1) begin start0 = 1'b0; start1 = 1'b0; end
      p  = (which != 0) ? pin1 : pin0;
      bs = (which != 0) ? busy1 : busy0;
      dn = (which != 0) ? done1 : done0;
      k = (off - 1) / D;
      if ((off - 1) % D == 0) bits[k] = p;
      else if (p !== bits[k]) unstable++;
      if (bs !== 1'b1 || dn !== 1'b0) unstable++;
    end
    for (int off = nbits * D + 1; off <= nbits * D + 40; off++) begin
      @(negedge CLK);
      p  = (which != 0) ? pin1 : pin0;
      bs = (which != 0) ? busy1 : busy0;
      dn = (which != 0) ? done1 : done0;
      if (dn === 1'b1) begin
        done_off = off;
        if (bs !== 1'b0 || p !== 1'b1) done_bad++;
        break;
      end
    end
    if (done_off >= 0) begin
      if (chain) begin
        data0 = nb; start0 = 1'b1;
      end else begin
        @(negedge CLK);
        dn = (which != 0) ? done1 : done0;
        if (dn !== 1'b0) done_bad++;
      end
    end
  endtask

  task automatic test_reset();
    int pin_bad = 0, busy_bad = 0, done_bad = 0;
    RSTn = 1'b0;
    for (int i = 0; i < 203; i++) begin
      @(negedge CLK);
      if (i == 2) RSTn = 1'b1;
      if (pin0 !== 1'b1 || pin1 !== 1'b1) pin_bad++;
      if (busy0 !== 1'b0 || busy1 !== 1'b0) busy_bad++;
      if (done0 !== 1'b0 || done1 !== 1'b0) done_bad++;
    end
    tests++; if (pin_bad !== 0) begin fails++; $display("FAIL reset_idle_pin: %0d bad cycles, required 0", pin_bad); end
    tests++; if (busy_bad !== 0) begin fails++; $display("FAIL reset_idle_busy: %0d bad cycles, required 0", busy_bad); end
    tests++; if (done_bad !== 0) begin fails++; $display("FAIL reset_idle_done: %0d bad cycles, required 0", done_bad); end
  endtask

  task automatic test_single();
    logic [11:0] bits; int unst, doff, dbad;
    en = 1'b1;
    capture(0, 1'b1, 8'hA5, 10, 1'b0, 8'h00, bits, unst, doff, dbad);
    tests++; if (bits !== 12'b0011_0100_1010) begin fails++; $display("FAIL a5_bits: got %b, required %b", bits, 12'b001101001010); end
    tests++; if (unst !== 0) begin fails++; $display("FAIL a5_stable: %0d bad cycles, required 0", unst); end
    tests++; if (doff !== 161) begin fails++; $display("FAIL a5_done_cycle: got %0d, required 161", doff); end
    tests++; if (dbad !== 0) begin fails++; $display("FAIL a5_done_pulse: %0d bad, required 0", dbad); end
  endtask

  task automatic test_parity();
    logic [11:0] bits; int unst, doff, dbad;
    capture(1, 1'b1, 8'h07, 12, 1'b0, 8'h00, bits, unst, doff, dbad);
    tests++; if (bits !== 12'b1110_0000_1110) begin fails++; $display("FAIL par07_bits: got %b, required %b", bits, 12'b111000001110); end
    tests++; if (unst !== 0 || dbad !== 0) begin fails++; $display("FAIL par07_stable: %0d/%0d bad, required 0/0", unst, dbad); end
    tests++; if (doff !== 193) begin fails++; $display("FAIL par07_done_cycle: got %0d, required 193", doff); end
    capture(1, 1'b1, 8'h03, 12, 1'b0, 8'h00, bits, unst, doff, dbad);
    tests++; if (bits !== 12'b1100_0000_0110) begin fails++; $display("FAIL par03_bits: got %b, required %b", bits, 12'b110000000110); end
    tests++; if (doff !== 193) begin fails++; $display("FAIL par03_done_cycle: got %0d, required 193", doff); end
  endtask

  task automatic test_ignored();
    logic [11:0] bits; int unst, doff, dbad;
    int idle_bad = 0, after_bad = 0;
    en = 1'b0;
    @(negedge CLK); data0 = 8'hFF; start0 = 1'b1;
    @(negedge CLK); start0 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (busy0 !== 1'b0 || pin0 !== 1'b1) idle_bad++;
    end
    tests++; if (idle_bad !== 0) begin fails++; $display("FAIL disabled_start: %0d busy cycles, required 0", idle_bad); end
    en = 1'b1;
    fork
      capture(0, 1'b1, 8'hC3, 10, 1'b0, 8'h00, bits, unst, doff, dbad);
      begin
        repeat (40) @(negedge CLK);
        data0 = 8'hFF; start0 = 1'b1;
        @(negedge CLK); start0 = 1'b0;
        repeat (30) @(negedge CLK);
        en = 1'b0; data0 = 8'h00; start0 = 1'b1;
        @(negedge CLK); start0 = 1'b0;
      end
    join
    tests++; if (bits !== 12'b0011_1000_0110) begin fails++; $display("FAIL midframe_bits: got %b, required %b", bits, 12'b001110000110); end
    tests++; if (doff !== 161 || unst !== 0) begin fails++; $display("FAIL midframe_done: done %0d unstable %0d, required 161 0", doff, unst); end
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (busy0 !== 1'b0) after_bad++;
    end
    tests++; if (after_bad !== 0) begin fails++; $display("FAIL no_queued_frame: %0d busy cycles, required 0", after_bad); end
    en = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [11:0] bits; int unst, doff, dbad;
    capture(0, 1'b1, 8'h55, 10, 1'b1, 8'h0F, bits, unst, doff, dbad);
    tests++; if (bits !== 12'b0010_1010_1010 || doff !== 161) begin fails++; $display("FAIL b2b_first: bits %b done %0d, required %b 161", bits, doff, 12'b001010101010); end
    capture(0, 1'b0, 8'h0F, 10, 1'b0, 8'h00, bits, unst, doff, dbad);
    tests++; if (bits !== 12'b0010_0001_1110) begin fails++; $display("FAIL b2b_second_bits: got %b, required %b", bits, 12'b001000011110); end
    tests++; if (doff !== 161 || unst !== 0 || dbad !== 0) begin fails++; $display("FAIL b2b_second_done: done %0d unstable %0d bad %0d, required 161 0 0", doff, unst, dbad); end
  endtask

  task automatic test_reset_mid();
    logic [11:0] bits; int unst, doff, dbad;
    int held_bad = 0;
    @(negedge CLK); data0 = 8'h96; start0 = 1'b1;
    @(negedge CLK); start0 = 1'b0;
    repeat (69) @(negedge CLK);
    #2 RSTn = 1'b0;
    #1;
    tests++; if (pin0 !== 1'b1 || busy0 !== 1'b0 || done0 !== 1'b0) begin
      fails++; $display("FAIL async_reset: pin %b busy %b done %b, required 1 0 0", pin0, busy0, done0);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      if (done0 !== 1'b0 || busy0 !== 1'b0 || pin0 !== 1'b1) held_bad++;
    end
    RSTn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (done0 !== 1'b0 || busy0 !== 1'b0) held_bad++;
    end
    tests++; if (held_bad !== 0) begin fails++; $display("FAIL reset_no_done: %0d bad cycles, required 0", held_bad); end
    capture(0, 1'b1, 8'h3C, 10, 1'b0, 8'h00, bits, unst, doff, dbad);
    tests++; if (bits !== 12'b0010_0111_1000) begin fails++; $display("FAIL post_reset_bits: got %b, required %b", bits, 12'b001001111000); end
    tests++; if (doff !== 161 || unst !== 0 || dbad !== 0) begin fails++; $display("FAIL post_reset_done: done %0d unstable %0d bad %0d, required 161 0 0", doff, unst, dbad); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_parity();
    test_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/tx_top.md
# tx_top

UART transmitter for the lab board, the sending counterpart of the existing UART receive path. It accepts one byte at a time through a start/busy/done handshake, generates its own bit-period timing from CLK, and drives a standard 8-N-1 (optionally parity, optionally 2 stop bits) frame on the TX pin. Byte sources are board switches, a loopback from the receive path, or any future on-chip producer.

## Interface
Parameters:
- BPS_DIV, 5208: CLK cycles per bit (50 MHz / 9600 baud); legal range 4..65535.
- PARITY_EN, 0: 1 inserts a parity bit between D7 and the stop bit(s).
- PARITY_ODD, 0: 1 selects odd parity, 0 selects even; ignored when PARITY_EN=0.
- STOP_BITS, 1: number of stop bits, 1 or 2.

Ports:
- CLK  input  1  system clock; all logic on the rising edge.
- RSTn  input  1  asynchronous active-low reset.
- TX_En_Sig  input  1  level enable (SW2); gates acceptance of new bytes only.
- TX_Start_Sig  input  1  request, sampled each cycle; one-cycle pulse expected.
- TX_Data  input  8  byte to send; sampled only in the accept cycle.
- TX_Pin_Out  output  1  serial line, registered; idle high.
- TX_Busy_Sig  output  1  high while a frame is in progress.
- TX_Done_Sig  output  1  one-cycle pulse when a frame completes.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Accept: in IDLE, TX_En_Sig=1 and TX_Start_Sig=1 in the same cycle. Latch TX_Data into the shift register, clear the bit counter and the baud counter, go to START.
- Start requests while not IDLE, or while TX_En_Sig=0, are ignored. They are not queued.
- Baud counter: 16 bits, counts 0..BPS_DIV-1 and wraps. Each wrap ends the current bit.
- START: line 0 for one bit, then go to DATA.
- DATA: 8 bits, LSB first. Shift right at each bit end. A 3-bit index counts 0..7. After bit 7, go to PARITY if PARITY_EN=1, otherwise go to STOP.
- PARITY: line = ^data, XOR 1 if PARITY_ODD. Computed from the latched byte. Lasts one bit, then go to STOP.
- STOP: line 1 for STOP_BITS bits, then go to IDLE and pulse TX_Done_Sig.
- TX_En_Sig falling mid-frame does not abort the frame. The frame completes normally.
- TX_Data changing mid-frame has no effect.
- Reset (asynchronous, any time including mid-frame):
  - state IDLE; all counters and the shift register cleared;
  - TX_Pin_Out=1, TX_Busy_Sig=0, TX_Done_Sig=0 immediately.

## Timing
- Let N be the accept edge and D = BPS_DIV.
- From cycle N+1: TX_Busy_Sig=1, TX_Pin_Out=0.
- Bit k (k=0 is the start bit) occupies cycles N+1+k·D through N+(k+1)·D, exactly D cycles each.
- Frame length F = (1+8+PARITY_EN+STOP_BITS) bits.
- In cycle N+F·D+1:
  - TX_Done_Sig=1 for exactly one cycle;
  - TX_Busy_Sig=0;
  - TX_Pin_Out stays 1.
- Back-to-back: a start request in the TX_Done_Sig cycle is accepted. The next start bit begins one cycle later, so there is no extra idle bit.
- TX_Pin_Out is a flop output: glitch-free and never X after reset.

## Test plan
Simulate with BPS_DIV=16 unless stated.
- Reset then idle:
  - stimulus: RSTn low 3 cycles, release, no requests for 200 cycles;
  - required: TX_Pin_Out=1, TX_Busy_Sig=0, TX_Done_Sig=0 throughout.
- Single byte 0xA5, 8-N-1:
  - stimulus: TX_En_Sig=1, TX_Start_Sig pulse;
  - required: line shows 0,1,0,1,0,0,1,0,1,1, each bit 16 cycles;
  - required: TX_Done_Sig exactly 161 cycles after the accept edge.
- Parity and stop bits, PARITY_EN=1, PARITY_ODD=0, STOP_BITS=2:
  - 0x07 → parity bit 1;
  - 0x03 → parity bit 0;
  - Done at 193 cycles.
- Ignored requests:
  - start pulses in the middle of a frame → no effect;
  - start with TX_En_Sig=0 → stays IDLE;
  - TX_Data changed mid-frame → transmitted byte unchanged.
- Back-to-back 0x55 then 0x0F:
  - stimulus: second start in the Done cycle;
  - required: second start bit begins the next cycle; 20 bits continuous; two Done pulses.
- Reset mid-frame:
  - stimulus: RSTn low during DATA bit 3;
  - required: TX_Pin_Out=1 and TX_Busy_Sig=0 asynchronously, no Done pulse;
  - required: after release, a new 0x3C frame transmits correctly.
